// File: rtl/mux_key_table.sv
// Runtime-loadable key/data lookup table with a registered valid/ready result stage.
// Lowest matching index wins; misses return a default (or zero) and are counted.
module mux_key_table #(
    parameter int NR_KEY      = 4,
    parameter int KEY_LEN     = 4,
    parameter int DATA_LEN    = 8,
    parameter bit HAS_DEFAULT = 1'b1,
    localparam int IDX_W      = $clog2(NR_KEY)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic [KEY_LEN-1:0]  wr_key,
    input  logic [DATA_LEN-1:0] wr_data,
    input  logic                wr_set,
    input  logic                clr,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [KEY_LEN-1:0]  in_key,
    input  logic [DATA_LEN-1:0] default_out,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_LEN-1:0] out_data,
    output logic                out_hit,
    output logic [IDX_W-1:0]    out_idx,
    output logic [NR_KEY-1:0]   entry_valid,
    output logic [15:0]         miss_cnt
);

    // Handshake: a request transfers on a rising edge where in_valid && in_ready;
    // a result transfers where out_valid && out_ready. in_ready = !out_valid || out_ready.

    logic [KEY_LEN-1:0]  key_q  [NR_KEY];
    logic [DATA_LEN-1:0] data_q [NR_KEY];
    logic [NR_KEY-1:0]   valid_q;

    logic                accept;
    logic                match_hit;
    logic [IDX_W-1:0]    match_idx;
    logic [DATA_LEN-1:0] match_data;

    assign in_ready    = !out_valid || out_ready;
    assign accept      = in_valid && in_ready;
    assign entry_valid = valid_q;

    // Descending scan so the lowest matching index overrides higher ones.
    always_comb begin
        match_hit  = 1'b0;
        match_idx  = '0;
        match_data = HAS_DEFAULT ? default_out : '0;
        for (int i = NR_KEY - 1; i >= 0; i--) begin
            if (valid_q[i] && (key_q[i] == in_key)) begin
                match_hit  = 1'b1;
                match_idx  = IDX_W'(i);
                match_data = data_q[i];
            end
        end
    end

    // Index compare per entry means out-of-range wr_idx selects nothing; clr drops any write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < NR_KEY; i++) begin
                key_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else if (clr) begin
            valid_q <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NR_KEY; i++) begin
                if (wr_idx == IDX_W'(i)) begin
                    key_q[i]   <= wr_key;
                    data_q[i]  <= wr_data;
                    valid_q[i] <= wr_set;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_hit   <= 1'b0;
            out_idx   <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= match_data;
            out_hit   <= match_hit;
            out_idx   <= match_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miss_cnt <= '0;
        end else if (accept && !match_hit && (miss_cnt != 16'hFFFF)) begin
            miss_cnt <= miss_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_mux_key_table.sv
// Directed bench for mux_key_table: table load, priority, miss default, clr,
// read-before-write, back-pressure, miss counter saturation and async reset.
module tb_mux_key_table;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [1:0] wr_idx;
    logic [3:0] wr_key;
    logic [7:0] wr_data;
    logic       wr_set;
    logic       clr;
    logic       in_valid;
    logic [3:0] in_key;
    logic [7:0] default_out;
    logic       out_ready;

    logic       in_ready, out_valid, out_hit;
    logic [7:0] out_data;
    logic [1:0] out_idx;
    logic [3:0] entry_valid;
    logic [15:0] miss_cnt;

    logic       z_in_ready, z_out_valid, z_out_hit;
    logic [7:0] z_out_data;
    logic [1:0] z_out_idx;
    logic [3:0] z_entry_valid;
    logic [15:0] z_miss_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mux_key_table #(.NR_KEY(4), .KEY_LEN(4), .DATA_LEN(8), .HAS_DEFAULT(1'b1)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx), .wr_key(wr_key),
        .wr_data(wr_data), .wr_set(wr_set), .clr(clr), .in_valid(in_valid),
        .in_ready(in_ready), .in_key(in_key), .default_out(default_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_hit(out_hit), .out_idx(out_idx), .entry_valid(entry_valid),
        .miss_cnt(miss_cnt)
    );

    mux_key_table #(.NR_KEY(4), .KEY_LEN(4), .DATA_LEN(8), .HAS_DEFAULT(1'b0)) dut_zero (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx), .wr_key(wr_key),
        .wr_data(wr_data), .wr_set(wr_set), .clr(clr), .in_valid(in_valid),
        .in_ready(z_in_ready), .in_key(in_key), .default_out(default_out),
        .out_valid(z_out_valid), .out_ready(out_ready), .out_data(z_out_data),
        .out_hit(z_out_hit), .out_idx(z_out_idx), .entry_valid(z_entry_valid),
        .miss_cnt(z_miss_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input logic [1:0] idx, input logic [3:0] key,
                               input logic [7:0] data, input logic set);
        wr_en = 1'b1; wr_idx = idx; wr_key = key; wr_data = data; wr_set = set;
        step();
        wr_en = 1'b0;
    endtask

    task automatic lookup(input logic [3:0] key, input logic [7:0] def);
        in_valid = 1'b1; in_key = key; default_out = def; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_idx = '0; wr_key = '0; wr_data = '0; wr_set = 1'b0;
        clr = 1'b0; in_valid = 1'b0; in_key = '0; default_out = '0; out_ready = 1'b0;
        #2;
        check("rst_entry_valid", 32'(entry_valid), 32'h0);
        check("rst_out_valid",   32'(out_valid),   32'h0);
        check("rst_in_ready",    32'(in_ready),    32'h1);
        check("rst_out_data",    32'(out_data),    32'h0);
        check("rst_miss_cnt",    32'(miss_cnt),    32'h0);
        step();
        step();
        rst = 1'b0;
        step();

        write_entry(2'd0, 4'd3, 8'hA0, 1'b1);
        write_entry(2'd1, 4'd5, 8'hB1, 1'b1);
        write_entry(2'd2, 4'd3, 8'hC2, 1'b1);
        check("load_entry_valid", 32'(entry_valid), 32'h7);

        lookup(4'd3, 8'h00);
        check("prio_out_valid", 32'(out_valid), 32'h1);
        check("prio_out_hit",   32'(out_hit),   32'h1);
        check("prio_out_idx",   32'(out_idx),   32'h0);
        check("prio_out_data",  32'(out_data),  32'hA0);

        lookup(4'd9, 8'h5A);
        check("miss_out_hit",   32'(out_hit),    32'h0);
        check("miss_out_idx",   32'(out_idx),    32'h0);
        check("miss_out_data",  32'(out_data),   32'h5A);
        check("miss_cnt_1",     32'(miss_cnt),   32'h1);
        check("nodef_out_data", 32'(z_out_data), 32'h00);
        check("nodef_out_hit",  32'(z_out_hit),  32'h0);
        check("nodef_miss_cnt", 32'(z_miss_cnt), 32'h1);

        write_entry(2'd0, 4'd3, 8'hA0, 1'b0);
        check("inval_entry_valid", 32'(entry_valid), 32'h6);
        lookup(4'd3, 8'h00);
        check("inval_out_idx",  32'(out_idx),  32'h2);
        check("inval_out_data", 32'(out_data), 32'hC2);

        clr = 1'b1;
        write_entry(2'd1, 4'd7, 8'hFF, 1'b1);
        clr = 1'b0;
        check("clr_entry_valid", 32'(entry_valid), 32'h0);
        lookup(4'd7, 8'h33);
        check("clr_out_hit",  32'(out_hit),  32'h0);
        check("clr_out_data", 32'(out_data), 32'h33);
        check("clr_miss_cnt", 32'(miss_cnt), 32'h2);

        write_entry(2'd0, 4'd3, 8'hA0, 1'b1);
        write_entry(2'd1, 4'd5, 8'hB1, 1'b1);
        write_entry(2'd2, 4'd3, 8'hC2, 1'b1);

        // Write and lookup of the same entry on one edge: lookup sees the old data.
        wr_en = 1'b1; wr_idx = 2'd1; wr_key = 4'd5; wr_data = 8'hEE; wr_set = 1'b1;
        lookup(4'd5, 8'h00);
        wr_en = 1'b0;
        check("rbw_old_hit",  32'(out_hit),  32'h1);
        check("rbw_old_idx",  32'(out_idx),  32'h1);
        check("rbw_old_data", 32'(out_data), 32'hB1);
        lookup(4'd5, 8'h00);
        check("rbw_new_data", 32'(out_data), 32'hEE);

        step();
        check("drain_out_valid", 32'(out_valid), 32'h0);

        out_ready = 1'b0; in_valid = 1'b1; in_key = 4'd3; default_out = 8'h5A;
        step();
        check("bp_first_valid", 32'(out_valid), 32'h1);
        check("bp_first_data",  32'(out_data),  32'hA0);
        check("bp_in_ready_0",  32'(in_ready),  32'h0);
        in_key = 4'd5;
        step();
        check("bp_hold_data_1", 32'(out_data), 32'hA0);
        check("bp_hold_idx_1",  32'(out_idx),  32'h0);
        step();
        check("bp_hold_data_2", 32'(out_data), 32'hA0);
        check("bp_in_ready_2",  32'(in_ready), 32'h0);
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'h1);
        step();
        check("bp_second_valid", 32'(out_valid), 32'h1);
        check("bp_second_data",  32'(out_data),  32'hEE);
        check("bp_second_idx",   32'(out_idx),   32'h1);
        in_key = 4'd9;
        step();
        check("bp_third_hit",  32'(out_hit),  32'h0);
        check("bp_third_data", 32'(out_data), 32'h5A);
        in_valid = 1'b0;
        step();
        check("bp_no_dup", 32'(out_valid), 32'h0);
        check("bp_miss_cnt", 32'(miss_cnt), 32'h3);

        in_valid = 1'b1; in_key = 4'd9; out_ready = 1'b1;
        repeat (65531) step();
        check("sat_below", 32'(miss_cnt), 32'hFFFE);
        step();
        check("sat_reach", 32'(miss_cnt), 32'hFFFF);
        repeat (5) step();
        check("sat_hold", 32'(miss_cnt), 32'hFFFF);
        check("sat_nodef", 32'(z_miss_cnt), 32'hFFFF);
        check("pre_rst_out_valid", 32'(out_valid), 32'h1);

        rst = 1'b1;
        #1;
        check("arst_out_valid",   32'(out_valid),   32'h0);
        check("arst_out_data",    32'(out_data),    32'h0);
        check("arst_out_hit",     32'(out_hit),     32'h0);
        check("arst_miss_cnt",    32'(miss_cnt),    32'h0);
        check("arst_entry_valid", 32'(entry_valid), 32'h0);
        check("arst_in_ready",    32'(in_ready),    32'h1);
        in_valid = 1'b0;
        step();
        rst = 1'b0;
        step();
        check("post_rst_no_beat", 32'(out_valid), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
